// File: rtl/mole_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mole_pkg
//  Description : Shared types and constants for the whack-a-mole scheduler:
//                FSM state encoding, LFSR geometry and width helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package mole_pkg;

    // 16-bit Galois LFSR, taps 16,14,13,11 (right-shifting form)
    localparam int          LFSR_W    = 16;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Game FSM states, explicitly encoded in 3 bits
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_GAP  = 3'd1,
        ST_UP   = 3'd2,
        ST_HIT  = 3'd3,
        ST_MISS = 3'd4,
        ST_OVER = 3'd5
    } mole_state_t;

    // Bits needed to index one of n holes (never less than 1)
    function automatic int hole_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Bits for a down-counter loaded with at most max(a,b)-1 (never less than 1)
    function automatic int timer_w(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mole_lfsr.sv
`default_nettype none
// ============================================================================
//  Module      : mole_lfsr
//  Description : Free-running 16-bit Galois LFSR used to pick the next hole.
//                Advances every cycle; reset loads SEED.
//  Revision    : 1.0 - initial release
// ============================================================================
module mole_lfsr
    import mole_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [LFSR_W-1:0] q
);

    // Shift right, folding the outgoing bit back in through the tap mask
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= SEED;
        end else begin
            q <= (q >> 1) ^ ({LFSR_W{q[0]}} & LFSR_TAPS);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mole_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : mole_scheduler
//  Description : Whack-a-mole game controller. Waits a gap, raises one
//                pseudo-random mole, judges button presses against a timeout,
//                and tracks score and lives until the game is over.
//  Revision    : 1.0 - initial release
// ============================================================================
module mole_scheduler
    import mole_pkg::*;
#(
    parameter int          N_HOLES    = 4,
    parameter int          GAP_CYCLES = 25_000_000,
    parameter int          UP_CYCLES  = 50_000_000,
    parameter int          LIVES      = 3,
    parameter int          SCORE_W    = 8,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [N_HOLES-1:0] hit_btn,
    output logic [N_HOLES-1:0] mole,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         lives,
    output logic               game_over,
    output logic               busy
);

    localparam int               HW         = hole_w(N_HOLES);
    localparam int               TW         = timer_w(GAP_CYCLES, UP_CYCLES);
    localparam logic [TW-1:0]    GAP_LOAD   = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0]    UP_LOAD    = TW'(UP_CYCLES - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [1:0]       LIVES_INIT = 2'(LIVES);

    mole_state_t        state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [N_HOLES-1:0] mole_q, mole_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [1:0]         lives_q, lives_d;
    logic               over_q, over_d;
    logic               busy_q, busy_d;
    logic [HW-1:0]      hole_q, hole_d;
    logic [N_HOLES-1:0] btn_q;

    logic [LFSR_W-1:0]  w_lfsr;
    logic [N_HOLES-1:0] w_press;
    logic [HW-1:0]      w_cand;
    logic [HW-1:0]      w_choose;
    logic               w_unused;

    mole_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .q       (w_lfsr)
    );

    // Only the low bits pick a hole; the rest just keep the sequence long
    assign w_unused = ^w_lfsr[LFSR_W-1:HW];

    // Rising-edge press detection and no-repeat hole selection
    assign w_press  = hit_btn & ~btn_q;
    assign w_cand   = w_lfsr[HW-1:0];
    assign w_choose = (w_cand == hole_q) ? (w_cand + HW'(1)) : w_cand;

    // Next-state logic for the game FSM and its counters
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        mole_d  = mole_q;
        score_d = score_q;
        lives_d = lives_q;
        over_d  = over_q;
        hole_d  = hole_q;
        unique case (state_q)
            ST_IDLE, ST_OVER: begin
                mole_d = '0;
                if (start) begin
                    score_d = '0;
                    lives_d = LIVES_INIT;
                    over_d  = 1'b0;
                    timer_d = GAP_LOAD;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (timer_q == '0) begin
                    hole_d  = w_choose;
                    mole_d  = N_HOLES'(1) << w_choose;
                    timer_d = UP_LOAD;
                    state_d = ST_UP;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_UP: begin
                // The correct button wins even alongside wrong ones or at timeout
                if (w_press[hole_q]) begin
                    state_d = ST_HIT;
                end else if (|w_press) begin
                    state_d = ST_MISS;
                end else if (timer_q == '0) begin
                    state_d = ST_MISS;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_HIT: begin
                mole_d  = '0;
                score_d = (score_q == SCORE_MAX) ? score_q : score_q + SCORE_W'(1);
                timer_d = GAP_LOAD;
                state_d = ST_GAP;
            end
            ST_MISS: begin
                mole_d  = '0;
                lives_d = lives_q - 2'd1;
                if (lives_q == 2'd1) begin
                    over_d  = 1'b1;
                    state_d = ST_OVER;
                end else begin
                    timer_d = GAP_LOAD;
                    state_d = ST_GAP;
                end
            end
            default: begin
                mole_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_GAP) || (state_d == ST_UP) ||
                 (state_d == ST_HIT) || (state_d == ST_MISS);
    end

    // State, counters, outputs and button history; reset drops the mole at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            mole_q  <= '0;
            score_q <= '0;
            lives_q <= '0;
            over_q  <= 1'b0;
            busy_q  <= 1'b0;
            hole_q  <= '0;
            btn_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            mole_q  <= mole_d;
            score_q <= score_d;
            lives_q <= lives_d;
            over_q  <= over_d;
            busy_q  <= busy_d;
            hole_q  <= hole_d;
            btn_q   <= hit_btn;
        end
    end

    assign mole      = mole_q;
    assign score     = score_q;
    assign lives     = lives_q;
    assign game_over = over_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mole_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mole_scheduler
//  Description : Scoreboard bench for mole_scheduler. Two instances share all
//                inputs (SCORE_W=8 and SCORE_W=2); every change of the output
//                snapshot is matched against the next queued expectation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mole_scheduler;

    localparam int          N    = 4;
    localparam int          G    = 4;
    localparam int          U    = 8;
    localparam int          L    = 3;
    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       start = 1'b0;
    logic [3:0] hit_btn = 4'b0;

    logic [3:0] mole_a;  logic [7:0] score_a; logic [1:0] lives_a; logic go_a; logic busy_a;
    logic [3:0] mole_b;  logic [1:0] score_b; logic [1:0] lives_b; logic go_b; logic busy_b;

    mole_scheduler #(.N_HOLES(N), .GAP_CYCLES(G), .UP_CYCLES(U), .LIVES(L),
                     .SCORE_W(8), .LFSR_SEED(SEED)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .hit_btn(hit_btn),
        .mole(mole_a), .score(score_a), .lives(lives_a), .game_over(go_a), .busy(busy_a));

    mole_scheduler #(.N_HOLES(N), .GAP_CYCLES(G), .UP_CYCLES(U), .LIVES(L),
                     .SCORE_W(2), .LFSR_SEED(SEED)) u_sat (
        .clk(clk), .reset_n(reset_n), .start(start), .hit_btn(hit_btn),
        .mole(mole_b), .score(score_b), .lives(lives_b), .game_over(go_b), .busy(busy_b));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] mole;
        logic [7:0] score;
        logic [1:0] lives;
        logic       over;
        logic       busy;
    } snap_t;

    typedef struct {
        snap_t s;
        int    at;
    } exp_t;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    bit    mon_en  = 1'b0;
    exp_t  sb[$];
    snap_t e;
    snap_t prev_a, prev_b, cur_a, cur_b;
    exp_t  x;
    logic [15:0] m_lfsr;
    int    m_last;
    int    m_hole;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    function automatic snap_t sat2(input snap_t s);
        snap_t r;
        r = s;
        r.score = (s.score > 8'd3) ? 8'd3 : s.score;
        return r;
    endfunction

    function automatic logic [15:0] lstep(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Monitor: whenever either DUT's outputs change, compare with the next expectation
    always @(negedge clk) begin
        if (mon_en) begin
            cur_a = {mole_a, score_a, lives_a, go_a, busy_a};
            cur_b = {mole_b, 6'b0, score_b, lives_b, go_b, busy_b};
            if (cur_a !== prev_a || cur_b !== prev_b) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_change: got %h expected %h (cycle %0d)", cur_a, prev_a, cyc);
                end else begin
                    x = sb.pop_front();
                    check("snapshot", 32'(cur_a), 32'(x.s));
                    check("sat_snapshot", 32'(cur_b), 32'(sat2(x.s)));
                    check("change_cycle", cyc, x.at);
                end
                prev_a = cur_a;
                prev_b = cur_b;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        if (reset_n) m_lfsr = lstep(m_lfsr);
        else         m_lfsr = SEED;
        cyc++;
        #1;
    endtask

    task automatic push_at(input int at);
        exp_t t;
        t.s  = e;
        t.at = at;
        sb.push_back(t);
    endtask

    // Gap of G cycles ending with the model's chosen hole rising
    task automatic do_gap();
        int cand;
        int prev;
        repeat (G - 1) tick();
        prev   = m_last;
        cand   = int'(m_lfsr[1:0]);
        m_hole = (cand == m_last) ? (cand + 1) % N : cand;
        e.mole = 4'b0001 << m_hole;
        push_at(cyc + 1);
        tick();
        m_last = m_hole;
        check("new_hole_differs", 32'(mole_a != (4'b0001 << prev)), 32'd1);
    endtask

    task automatic start_game();
        start   = 1'b1;
        e.score = 8'd0;
        e.lives = 2'(L);
        e.over  = 1'b0;
        e.busy  = 1'b1;
        push_at(cyc + 1);
        tick();
        start = 1'b0;
        do_gap();
    endtask

    // Wait until UP cycle i, drive btn during it, and let the decision edge pass
    task automatic up_press(input int i, input logic [3:0] btn);
        repeat (i - 1) tick();
        hit_btn = btn;
        tick();
    endtask

    task automatic resolve_hit(input bit hold);
        if (!hold) hit_btn = 4'b0;
        e.mole  = 4'b0;
        e.score = e.score + 8'd1;
        push_at(cyc + 1);
        tick();
        do_gap();
    endtask

    task automatic resolve_miss();
        e.mole  = 4'b0;
        e.lives = e.lives - 2'd1;
        if (e.lives == 2'd0) begin
            e.over = 1'b1;
            e.busy = 1'b0;
        end
        push_at(cyc + 1);
        tick();
        if (e.lives != 2'd0) do_gap();
    endtask

    initial begin
        // Reset / idle
        e      = '0;
        prev_a = '0;
        prev_b = '0;
        m_lfsr = SEED;
        m_last = 0;
        #1 reset_n = 1'b0;
        #1;
        check("reset_outputs", 32'({mole_a, score_a, lives_a, go_a, busy_a}), 32'd0);
        check("reset_outputs_sat", 32'({mole_b, score_b, lives_b, go_b, busy_b}), 32'd0);
        mon_en = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        hit_btn = 4'b0101; tick();
        hit_btn = 4'b1010; tick();
        hit_btn = 4'b0000; tick();
        check("idle_score", 32'(score_a), 32'd0);
        check("idle_lives", 32'(lives_a), 32'd0);

        // Timeout: mole up, no presses, one life lost
        start_game();
        up_press(U, 4'b0000);
        resolve_miss();

        // Correct hit 3 cycles into UP, button held into the next round
        up_press(3, 4'b0001 << m_hole);
        resolve_hit(1'b1);

        // Release the held button, then correct + wrong in the same cycle
        tick();
        hit_btn = 4'b0;
        up_press(3, (4'b0001 << m_hole) | (4'b0001 << ((m_hole + 1) % N)));
        resolve_hit(1'b0);

        // Start mid-game is ignored; correct press on the final UP cycle
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_ignored_busy", 32'(busy_a), 32'd1);
        up_press(U - 1, 4'b0001 << m_hole);
        resolve_hit(1'b0);

        // Two more hits push the narrow score into saturation
        up_press(1, 4'b0001 << m_hole);
        resolve_hit(1'b0);
        up_press(5, 4'b0001 << m_hole);
        resolve_hit(1'b0);

        // Wrong button, then a final timeout ends the game
        up_press(2, 4'b0001 << ((m_hole + 1) % N));
        hit_btn = 4'b0;
        resolve_miss();
        up_press(U, 4'b0000);
        resolve_miss();

        // Game over: buttons do nothing, outputs held
        hit_btn = 4'b1111; tick();
        hit_btn = 4'b0000; tick();
        check("over_flag", 32'(go_a), 32'd1);
        check("over_busy", 32'(busy_a), 32'd0);
        check("over_score", 32'(score_a), 32'd5);
        check("over_score_sat", 32'(score_b), 32'd3);

        // Restart, then reset in the middle of UP
        start_game();
        tick();
        tick();
        reset_n = 1'b0;
        m_lfsr  = SEED;
        m_last  = 0;
        e       = '0;
        push_at(cyc);
        #1;
        check("async_mole_drop", 32'(mole_a), 32'd0);
        check("async_mole_drop_sat", 32'(mole_b), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // A fresh game after reset follows the reseeded sequence
        start_game();
        up_press(U, 4'b0000);
        resolve_miss();
        repeat (3) tick();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
